// File: rtl/modulo_counter_chain_pkg.sv
// Shared defaults for the modulo counter chain: digit width, the prescale
// values for a 50 MHz board clock, and the stage count of an hh:mm:ss clock.
package modulo_counter_chain_pkg;

  localparam int DIGIT_W_DEFAULT    = 4;
  localparam int PRESCALE_1S        = 50_000_000;
  localparam int PRESCALE_100MS     = 5_000_000;
  localparam int PRESCALE_W_DEFAULT = 26;
  localparam int STAGES_HMS         = 6;

endpackage

// File: rtl/modulo_digit.sv
// One digit of the chain: a registered digit with a runtime limit, up/down
// stepping, a boundary flag for the stage above, and a clamped preset.
module modulo_digit
  import modulo_counter_chain_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               step_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               boundary_out
);

  // Counting up, anything at or past the limit is the boundary, so a digit
  // stranded above a lowered limit wraps to zero on its next step.
  always_comb begin
    boundary_out = up ? (digit >= limit) : (digit == '0);
  end

  always_comb begin
    next_digit = digit;
    if (load) begin
      next_digit = (load_digit > limit) ? limit : load_digit;
    end else if (step_in) begin
      if (up) begin
        next_digit = boundary_out ? '0 : digit + DIGIT_W'(1);
      end else if (boundary_out || (digit > limit)) begin
        next_digit = limit;
      end else begin
        next_digit = digit - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else begin
      digit <= next_digit;
    end
  end

endmodule

// File: rtl/modulo_counter_chain.sv
// Cascade of modulo digits advanced by an internal tick prescaler, with a
// chain-wrap carry pulse and an alarm comparator on the next count value.
module modulo_counter_chain
  import modulo_counter_chain_pkg::*;
#(
  parameter int STAGES     = STAGES_HMS,
  parameter int DIGIT_W    = DIGIT_W_DEFAULT,
  parameter int PRESCALE   = PRESCALE_100MS,
  parameter int PRESCALE_W = PRESCALE_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      up,
  input  logic                      load,
  input  logic [STAGES*DIGIT_W-1:0] load_value,
  input  logic [STAGES*DIGIT_W-1:0] limits,
  input  logic                      alarm_en,
  input  logic [STAGES*DIGIT_W-1:0] alarm_value,
  input  logic                      alarm_clr,
  output logic [STAGES*DIGIT_W-1:0] count,
  output logic                      tick,
  output logic                      carry_out,
  output logic                      alarm,
  output logic                      alarm_flag
);

  localparam int CW = STAGES * DIGIT_W;
  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [STAGES-1:0]     step_in;
  logic [STAGES-1:0]     boundary;
  logic [CW-1:0]         next_count;
  logic                  chain_wrap;
  logic                  alarm_hit;

  // A load restarts the tick period from zero and swallows any tick that
  // would otherwise have been issued on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (load) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        pre_cnt <= pre_cnt + PRESCALE_W'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Enables are formed combinationally so every stage moves on the same edge.
  always_comb begin
    logic run;
    run = tick;
    for (int i = 0; i < STAGES; i++) begin
      step_in[i] = run;
      run        = run & boundary[i];
    end
    chain_wrap = run;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    modulo_digit #(
      .DIGIT_W(DIGIT_W)
    ) u_digit (
      .clk         (clk),
      .reset       (reset),
      .up          (up),
      .step_in     (step_in[g]),
      .load        (load),
      .load_digit  (load_value[g*DIGIT_W +: DIGIT_W]),
      .limit       (limits[g*DIGIT_W +: DIGIT_W]),
      .digit       (count[g*DIGIT_W +: DIGIT_W]),
      .next_digit  (next_count[g*DIGIT_W +: DIGIT_W]),
      .boundary_out(boundary[g])
    );
  end

  // Matching on the next value, only when the count is being written,
  // keeps a parked count from re-firing the alarm every cycle.
  assign alarm_hit = alarm_en & (load | tick) & (next_count == alarm_value);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_out  <= 1'b0;
      alarm      <= 1'b0;
      alarm_flag <= 1'b0;
    end else begin
      carry_out <= chain_wrap & ~load;
      alarm     <= alarm_hit;
      if (alarm_hit) begin
        alarm_flag <= 1'b1;
      end else if (alarm_clr) begin
        alarm_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modulo_counter_chain.sv
// Directed scenarios followed by random traffic, all checked against a
// digit-list reference model of the counter chain.
module tb_modulo_counter_chain;

  localparam int ST = 3;
  localparam int DW = 4;
  localparam int PS = 4;
  localparam int CW = ST * DW;

  logic          clk;
  logic          reset;
  logic          en;
  logic          up;
  logic          load;
  logic [CW-1:0] load_value;
  logic [CW-1:0] limits;
  logic          alarm_en;
  logic [CW-1:0] alarm_value;
  logic          alarm_clr;
  logic [CW-1:0] count;
  logic          tick;
  logic          carry_out;
  logic          alarm;
  logic          alarm_flag;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_dig[ST];
  int m_pre   = 0;
  bit m_tick  = 0;
  bit m_carry = 0;
  bit m_alarm = 0;
  bit m_flag  = 0;

  modulo_counter_chain #(
    .STAGES    (ST),
    .DIGIT_W   (DW),
    .PRESCALE  (PS),
    .PRESCALE_W(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .limits     (limits),
    .alarm_en   (alarm_en),
    .alarm_value(alarm_value),
    .alarm_clr  (alarm_clr),
    .count      (count),
    .tick       (tick),
    .carry_out  (carry_out),
    .alarm      (alarm),
    .alarm_flag (alarm_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fld(logic [CW-1:0] v, int i);
    return int'(v[DW*i +: DW]);
  endfunction

  function automatic logic [CW-1:0] pack(int d[ST]);
    logic [CW-1:0] p;
    p = '0;
    for (int i = 0; i < ST; i++) p[DW*i +: DW] = DW'(d[i]);
    return p;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".count"}, 32'(count), 32'(pack(m_dig)));
    check({tag, ".tick"}, 32'(tick), 32'(m_tick));
    check({tag, ".carry"}, 32'(carry_out), 32'(m_carry));
    check({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
    check({tag, ".flag"}, 32'(alarm_flag), 32'(m_flag));
  endtask

  task automatic model_zero();
    for (int i = 0; i < ST; i++) m_dig[i] = 0;
    m_pre = 0; m_tick = 0; m_carry = 0; m_alarm = 0; m_flag = 0;
  endtask

  // Predict one clock edge from the current inputs, then compare after it.
  task automatic cycle(string tag = "cyc");
    int nd[ST];
    int npre, lim, d;
    bit ntick, ncarry, nalarm, nflag, prop, b;
    nd = m_dig; npre = m_pre; ntick = 0; ncarry = 0;
    if (load) begin
      for (int i = 0; i < ST; i++)
        nd[i] = (fld(load_value, i) > fld(limits, i)) ? fld(limits, i) : fld(load_value, i);
      npre = 0;
    end else begin
      if (m_tick) begin
        prop = 1;
        for (int i = 0; i < ST; i++) begin
          if (prop) begin
            lim = fld(limits, i);
            d   = m_dig[i];
            b   = up ? (d >= lim) : (d == 0);
            if (up) nd[i] = b ? 0 : d + 1;
            else    nd[i] = (b || d > lim) ? lim : d - 1;
            prop = b;
          end
        end
        ncarry = prop;
      end
      if (en) begin
        if (m_pre == PS - 1) begin npre = 0; ntick = 1; end
        else npre = m_pre + 1;
      end
    end
    nalarm = alarm_en && (load || m_tick) && (pack(nd) == alarm_value);
    nflag  = nalarm ? 1'b1 : (alarm_clr ? 1'b0 : m_flag);
    @(posedge clk);
    #1;
    if (!reset) begin
      model_zero();
    end else begin
      m_dig = nd; m_pre = npre; m_tick = ntick;
      m_carry = ncarry; m_alarm = nalarm; m_flag = nflag;
    end
    check_all(tag);
  endtask

  task automatic wait_tick(string tag);
    for (int k = 0; k < 2 * PS && !m_tick; k++) cycle(tag);
    check({tag, ".tick_seen"}, 32'(tick), 32'd1);
  endtask

  task automatic do_load(logic [CW-1:0] v, string tag);
    load_value = v;
    load = 1'b1;
    cycle(tag);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    load_value = '0; limits = 12'h999; alarm_en = 1'b0;
    alarm_value = '0; alarm_clr = 1'b0;
    #2 reset = 1'b0;
    #1 check_all("reset");
    cycle("reset_hold");
    cycle("reset_hold");
    reset = 1'b1;
    en = 1'b1;

    // Prescale by 4: first tick after four cycles, count advances on the next edge
    repeat (4) cycle("p1");
    check("p1_tick_at_4", 32'(tick), 32'd1);
    check("p1_count_before", 32'(count), 32'h000);
    cycle("p1");
    check("p1_count_1", 32'(count), 32'h001);
    repeat (3) cycle("p1");
    check("p1_tick_at_8", 32'(tick), 32'd1);
    cycle("p1");
    check("p1_count_2", 32'(count), 32'h002);
    en = 1'b0;
    repeat (3) cycle("p1_hold");
    check("p1_hold_count", 32'(count), 32'h002);
    en = 1'b1;
    repeat (3) cycle("p1_resume");
    check("p1_phase_kept", 32'(tick), 32'd1);
    cycle("p1_resume");
    check("p1_count_3", 32'(count), 32'h003);

    // Whole-chain wrap with carry
    limits = 12'h099;
    do_load(12'h099, "p2_load");
    check("p2_loaded", 32'(count), 32'h099);
    wait_tick("p2");
    cycle("p2");
    check("p2_wrap_count", 32'(count), 32'h000);
    check("p2_wrap_carry", 32'(carry_out), 32'd1);
    cycle("p2");
    check("p2_carry_one_cycle", 32'(carry_out), 32'd0);
    limits = 12'h059;
    do_load(12'h059, "p2b_load");
    wait_tick("p2b");
    cycle("p2b");
    check("p2b_wrap_59", 32'(count), 32'h000);
    check("p2b_carry", 32'(carry_out), 32'd1);

    // Counting down wraps to the limits
    up = 1'b0;
    do_load(12'h000, "p3_load");
    wait_tick("p3");
    cycle("p3");
    check("p3_down_wrap", 32'(count), 32'h059);
    check("p3_down_carry", 32'(carry_out), 32'd1);
    wait_tick("p3");
    cycle("p3");
    check("p3_down_58", 32'(count), 32'h058);
    check("p3_no_carry", 32'(carry_out), 32'd0);

    // Preset clamps to the limits and beats a coincident tick
    up = 1'b1;
    do_load(12'h073, "p4_load");
    check("p4_clamped", 32'(count), 32'h053);
    wait_tick("p4");
    do_load(12'h021, "p4_load_vs_tick");
    check("p4_load_wins", 32'(count), 32'h021);
    check("p4_no_carry", 32'(carry_out), 32'd0);
    check("p4_tick_suppressed", 32'(tick), 32'd0);

    // Alarm pulse, sticky flag, clear, and set-beats-clear
    limits = 12'h999;
    alarm_en = 1'b1;
    alarm_value = 12'h012;
    do_load(12'h011, "p5_load");
    wait_tick("p5");
    cycle("p5");
    check("p5_count_12", 32'(count), 32'h012);
    check("p5_alarm_pulse", 32'(alarm), 32'd1);
    check("p5_flag_set", 32'(alarm_flag), 32'd1);
    cycle("p5");
    check("p5_alarm_one_cycle", 32'(alarm), 32'd0);
    alarm_clr = 1'b1;
    cycle("p5_clr");
    check("p5_flag_cleared", 32'(alarm_flag), 32'd0);
    do_load(12'h012, "p5_set_and_clr");
    check("p5_set_wins", 32'(alarm_flag), 32'd1);
    alarm_clr = 1'b0;
    repeat (2) cycle("p5_static");
    check("p5_static_no_refire", 32'(alarm), 32'd0);

    // Asynchronous reset between clock edges
    alarm_en = 1'b0;
    do_load(12'h037, "p6_load");
    repeat (2) cycle("p6");
    #2 reset = 1'b0;
    #1;
    model_zero();
    check("p6_async_count", 32'(count), 32'h000);
    check("p6_async_flag", 32'(alarm_flag), 32'd0);
    check_all("p6_async");
    cycle("p6_hold");
    reset = 1'b1;
    repeat (4) cycle("p6_resume");
    check("p6_resume_tick", 32'(tick), 32'd1);
    cycle("p6_resume");
    check("p6_resume_count", 32'(count), 32'h001);

    // Random traffic over a small count space so wraps and alarms are frequent
    for (int n = 0; n < 800; n++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      load = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < ST; i++) load_value[DW*i +: DW] = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0)
        for (int i = 0; i < ST; i++) limits[DW*i +: DW] = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        alarm_en = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < ST; i++) alarm_value[DW*i +: DW] = DW'($urandom_range(0, 3));
      end
      alarm_clr = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    load = 1'b0;
    alarm_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modulo_counter_chain.md
Name: modulo_counter_chain

Overview:
Parametrised cascade of STAGES modulo digit counters driven by an internal tick prescaler. It generalises the fixed six-digit clock chain with the following:
- configurable stage count, digit width and prescale;
- per-stage runtime limits;
- up/down direction and synchronous preset;
- chain-wrap carry and an alarm comparator.

It sits between the board clock and the display/BCD decode logic in clock, timer and stopwatch designs.

Parameters:
STAGES, 6, number of cascaded digit stages (1..8)
DIGIT_W, 4, bits per digit
PRESCALE, 5000000, clk cycles per count tick (>=1)
PRESCALE_W, 26, prescaler counter width; must satisfy 2^PRESCALE_W >= PRESCALE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
en  in  1  run enable; low freezes the prescaler and all digits
up  in  1  1 = count up, 0 = count down
load  in  1  synchronous preset strobe, active-high
load_value  in  STAGES*DIGIT_W  preset digits; stage 0 is in the LSBs
limits  in  STAGES*DIGIT_W  per-stage maximum digit value; stage 0 is in the LSBs
alarm_en  in  1  enables alarm matching
alarm_value  in  STAGES*DIGIT_W  alarm compare pattern
alarm_clr  in  1  clears alarm_flag
count  out  STAGES*DIGIT_W  current digits, registered
tick  out  1  one-cycle pulse on each count step
carry_out  out  1  one-cycle pulse when the whole chain wraps
alarm  out  1  one-cycle pulse on an alarm match
alarm_flag  out  1  sticky alarm indicator

Behaviour:
Reset (asynchronous, active-low):
- count, prescaler, tick, carry_out, alarm and alarm_flag all go to 0 immediately.
- Reset mid-count aborts any pending tick.

Prescaler:
- While en=1, it counts 0..PRESCALE-1.
- tick is registered high for exactly one cycle in the clk cycle after the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
- en=0 holds the prescaler value; it does not clear it.
- PRESCALE=1 gives tick on every enabled cycle.

Digit stepping (on the edge where tick=1):
- Stage 0 always steps.
- Stage i steps only if every stage below i is at its boundary. All stages update on the same edge; there is no ripple latency.
- Up: the boundary is digit >= limit. At the boundary the digit goes to 0, otherwise digit+1.
- Down: the boundary is digit == 0. At the boundary the digit goes to limit. If digit > limit it goes to limit, otherwise digit-1.
- A runtime limit change never leaves a digit stuck: an out-of-range digit resolves on its next step.

carry_out:
- Registered pulse, one cycle, on the edge after a tick in which all stages were at their boundary.
- Up wraps to all-zeros; down wraps to all-limits.

load:
- Synchronous and takes priority over tick in the same cycle.
- Each digit is set to min(load_value digit, limit digit).
- Clears the prescaler to 0.
- Suppresses tick and carry_out for that cycle.
- load acts even when en=0.

Alarm:
- When alarm_en=1 and a tick step or a load produces a next count equal to alarm_value, alarm pulses for one cycle, concurrent with the count update, and alarm_flag is set.
- alarm_clr clears alarm_flag. If a set and alarm_clr occur in the same cycle, the set wins.
- A static match without a count change does not re-fire.

Direction change:
- A change of up takes effect on the next tick. It causes no spurious step.

Decomposition:
- A shared header holds default constants: DIGIT_W, the 50 MHz 1 s and 0.1 s prescale values, and STAGES_HMS = 6.
- One sub-module, modulo_digit: a single stage with digit register, limit, up, step_in, boundary_out and load/clamp logic.
- The top level instantiates STAGES of modulo_digit in a generate loop, plus the prescaler, carry and alarm logic.

Test Plan:
1. PRESCALE=4, en=1, up=1, from reset -> tick high on cycles 4, 8, 12; count = 1, 2, 3 after each; en=0 for 3 cycles mid-count -> count and tick phase held.
2. STAGES=2, limits={9,9}, load 99, PRESCALE=1 -> next tick count=00, carry_out=1 for one cycle; limits={5,9} -> wrap at 59->00.
3. up=0, limits={5,9}, load 00, one tick -> count=59, carry_out=1; next tick -> 58, no carry.
4. limits={5,9}, load_value={7,3} -> count=53; load and tick asserted in the same cycle -> load wins, no tick step, no carry.
5. alarm_en=1, alarm_value=0x12, count 11, tick -> count 12, alarm pulse, alarm_flag=1; alarm_clr -> 0; alarm_clr coincident with a new match -> alarm_flag stays 1.
6. Count at 37 with reset asserted between clk edges -> count=00 and all outputs 0 immediately; release -> counting resumes from 0 after PRESCALE cycles.
